io_peripheral_bank: RTL
=======================

// Module: io_peripheral_bank
// PURPOSE
//  Responder end of the processor's memory-mapped I/O port (16 word addresses, 0x7FF0-0x7FFF).
//  Accepts single-cycle writes (IOWriteEn/IOAddr/IOWriteData) into peripheral registers and returns
//  IOReadData combinationally for the addressed register, so a single-cycle core reads it in the same cycle.
//  Hosts LED and display registers, a programmable game-tick timer and debounced button inputs with sticky events.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000   consecutive stable synchronized cycles before a button level change is accepted
//  NUM_BTN          4       number of button inputs (1..8)
//  ID_VALUE         32'h534E4B01  constant returned at address 0x6
// PORTS
//  CLK          in   1   system clock; all state updates on posedge
//  RESET        in   1   asynchronous, active-high reset
//  IOWriteData  in   32  write data from core
//  IOAddr       in   4   register address (word index within I/O range)
//  IOWriteEn    in   1   1: write IOWriteData to register IOAddr at next posedge
//  IOReadData   out  32  read data for register IOAddr (combinational)
//  BTN          in   NUM_BTN  raw asynchronous button inputs, active-high
//  LED          out  8   LED register contents
//  DISP         out  16  display value register contents
//  TICK         out  1   one-cycle pulse per timer period
// BEHAVIOUR
//  Register map (unused bits read 0; unlisted addresses read 0, writes ignored):
//   0x0 LED     RW [7:0]
//   0x1 DISP    RW [15:0]
//   0x2 RELOAD  RW [23:0] tick period in CLK cycles; 0 = timer disabled
//   0x3 TCOUNT  RO [15:0] ticks since last clear, wraps 0xFFFF->0; any write clears
//   0x4 BTNLVL  RO [NUM_BTN-1:0] debounced button levels
//   0x5 BTNEVT  W1C [NUM_BTN-1:0] sticky rising-edge events; write 1 clears bit, 0 leaves it
//   0x6 ID      RO ID_VALUE
//  Reset: LED=0, DISP=0, RELOAD=0, TCOUNT=0, timer count=0, TICK=0, sync flops=0, BTNLVL=0, BTNEVT=0,
//   debounce counters=0. Reset mid-operation aborts any pending debounce or timer period immediately.
//  Write timing: register updated at the posedge where IOWriteEn=1; a read of the same address in that
//   cycle returns the old value, the next cycle returns the new one.
//  Timer: down-counter CNT. Write to RELOAD loads CNT=new_value-1 and suppresses TICK that cycle.
//   Else if RELOAD!=0: CNT==0 -> TICK=1 (registered, one cycle), CNT<=RELOAD-1; otherwise CNT<=CNT-1.
//   RELOAD=1 -> TICK every cycle. RELOAD=0 -> CNT held at 0, TICK=0.
//  TCOUNT increments on each TICK. Write to 0x3 coinciding with TICK -> TCOUNT=1 (clear then count).
//  Buttons: 2-flop synchronizer per bit. Per-bit counter counts cycles where sync!=BTNLVL, reset to 0
//   when equal; on reaching DEBOUNCE_CYCLES-1 BTNLVL bit toggles and counter clears.
//   Debounce latency = 2 sync cycles + DEBOUNCE_CYCLES cycles after a stable input edge.
//  BTNEVT bit set on BTNLVL 0->1. Set and W1C of the same bit in the same cycle -> bit stays 1.
//  IOReadData is a pure mux of current register state on IOAddr; independent of IOWriteEn.
// TESTING
//  Reset then read 0x0..0xF -> 0x6 returns 0x534E4B01, all others 0; LED=0, DISP=0, TICK=0.
//  Write 0x2=5 -> TICK pulses every 5 cycles, first 5 cycles after write; after 3 ticks TCOUNT reads 3;
//   write 0x2=0 -> no further TICK.
//  Write 0x3 on the exact cycle TICK=1 -> TCOUNT reads 1; TCOUNT at 0xFFFF plus one tick -> 0.
//  DEBOUNCE_CYCLES=8: BTN[1] glitch high 5 cycles -> BTNLVL/BTNEVT unchanged; held high 20 cycles ->
//   BTNLVL=0x2 at 2+8 cycles after edge, BTNEVT=0x2; release -> BTNLVL=0, BTNEVT stays 0x2.
//  Write 0x5=0x2 on same cycle BTN[1] new rise is accepted -> BTNEVT remains 0x2; later write 0x5=0x2 -> 0.
//  Write 0x0=0xFFFFFFA5 -> LED=0xA5, read 0x0 returns 0xA5; assert RESET mid timer period -> all outputs 0.

Source files
------------

// File: rtl/io_peripheral_bank.sv
// Memory-mapped peripheral bank: LED/display registers, game-tick timer and debounced buttons.
// Reads are a pure combinational mux so a single-cycle core sees data in the same cycle.
`timescale 1ns/1ps
module io_peripheral_bank #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned NUM_BTN         = 4,
  parameter logic [31:0] ID_VALUE        = 32'h534E4B01
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        IOWriteData,
  input  logic [3:0]         IOAddr,
  input  logic               IOWriteEn,
  output logic [31:0]        IOReadData,
  input  logic [NUM_BTN-1:0] BTN,
  output logic [7:0]         LED,
  output logic [15:0]        DISP,
  output logic               TICK
);
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] A_LED    = 4'h0;
  localparam logic [3:0] A_DISP   = 4'h1;
  localparam logic [3:0] A_RELOAD = 4'h2;
  localparam logic [3:0] A_TCOUNT = 4'h3;
  localparam logic [3:0] A_BTNLVL = 4'h4;
  localparam logic [3:0] A_BTNEVT = 4'h5;
  localparam logic [3:0] A_ID     = 4'h6;

  logic [7:0]                  r_led;
  logic [15:0]                 r_disp;
  logic [23:0]                 r_reload;
  logic [23:0]                 r_cnt;
  logic                        r_tick;
  logic [15:0]                 r_tcount;
  logic [NUM_BTN-1:0]          r_sync1;
  logic [NUM_BTN-1:0]          r_sync2;
  logic [NUM_BTN-1:0]          r_lvl;
  logic [NUM_BTN-1:0]          r_evt;
  logic [NUM_BTN-1:0][DBW-1:0] r_db_cnt;

  logic               w_wr_led;
  logic               w_wr_disp;
  logic               w_wr_reload;
  logic               w_wr_tcount;
  logic               w_wr_evt;
  logic [NUM_BTN-1:0] w_accept;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_evt_clr;
  logic               w_unused_wdata;

  assign w_wr_led       = IOWriteEn && (IOAddr == A_LED);
  assign w_wr_disp      = IOWriteEn && (IOAddr == A_DISP);
  assign w_wr_reload    = IOWriteEn && (IOAddr == A_RELOAD);
  assign w_wr_tcount    = IOWriteEn && (IOAddr == A_TCOUNT);
  assign w_wr_evt       = IOWriteEn && (IOAddr == A_BTNEVT);
  assign w_evt_clr      = w_wr_evt ? IOWriteData[NUM_BTN-1:0] : '0;
  assign w_unused_wdata = ^IOWriteData[31:24];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_led  <= '0;
      r_disp <= '0;
    end else begin
      if (w_wr_led)  r_led  <= IOWriteData[7:0];
      if (w_wr_disp) r_disp <= IOWriteData[15:0];
    end
  end

  // Down-counter reloads to RELOAD-1 so TICK repeats every RELOAD cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_reload <= '0;
      r_cnt    <= '0;
      r_tick   <= 1'b0;
    end else if (w_wr_reload) begin
      r_reload <= IOWriteData[23:0];
      r_cnt    <= (IOWriteData[23:0] == 24'd0) ? 24'd0 : IOWriteData[23:0] - 24'd1;
      r_tick   <= 1'b0;
    end else if (r_reload != 24'd0) begin
      if (r_cnt == 24'd0) begin
        r_tick <= 1'b1;
        r_cnt  <= r_reload - 24'd1;
      end else begin
        r_tick <= 1'b0;
        r_cnt  <= r_cnt - 24'd1;
      end
    end else begin
      r_tick <= 1'b0;
      r_cnt  <= '0;
    end
  end

  // A clear that lands on a tick keeps that tick, leaving the count at 1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)            r_tcount <= '0;
    else if (w_wr_tcount) r_tcount <= {15'd0, r_tick};
    else if (r_tick)      r_tcount <= r_tcount + 16'd1;
  end

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NUM_BTN; i++)
      w_accept[i] = (r_sync2[i] != r_lvl[i]) && (r_db_cnt[i] == DB_LAST);
  end
  assign w_rise = w_accept & ~r_lvl;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_lvl    <= '0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= BTN;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_db_cnt[i] <= '0;
          r_lvl[i]    <= ~r_lvl[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // New events win over a simultaneous write-one-to-clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_evt <= '0;
    else       r_evt <= (r_evt & ~w_evt_clr) | w_rise;
  end

  always_comb begin
    IOReadData = '0;
    case (IOAddr)
      A_LED:    IOReadData[7:0]         = r_led;
      A_DISP:   IOReadData[15:0]        = r_disp;
      A_RELOAD: IOReadData[23:0]        = r_reload;
      A_TCOUNT: IOReadData[15:0]        = r_tcount;
      A_BTNLVL: IOReadData[NUM_BTN-1:0] = r_lvl;
      A_BTNEVT: IOReadData[NUM_BTN-1:0] = r_evt;
      A_ID:     IOReadData              = ID_VALUE;
      default:  IOReadData              = '0;
    endcase
  end

  assign LED  = r_led;
  assign DISP = r_disp;
  assign TICK = r_tick;
endmodule
